pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Parametrised stall/flush/forwarding controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It generates per-stage load and flush enables for the PC and the four stage registers. It also produces forwarding selects for the EX operands, freezes the pipeline on outstanding instruction/data memory responses, and flags memory timeouts. It sits beside the datapath and replaces the constant `load = 1` stage enables.

## Interface
Parameters:
- `REG_W`, 5: register index width.
- `MAX_WAIT`, 15: consecutive frozen cycles tolerated before timeout; legal range 1 to 255.
- `CNT_W`, 32: performance counter width.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `imem_resp`  in  1: instruction word valid this cycle.
- `dmem_req`  in  1: MEM stage has a read or write outstanding.
- `dmem_resp`  in  1: data access completes this cycle.
- `id_rs1`, `id_rs2`  in  REG_W: ID source registers.
- `id_use_rs1`, `id_use_rs2`  in  1: source actually read by the ID instruction.
- `ex_rs1`, `ex_rs2`  in  REG_W: EX source registers.
- `ex_rd`, `mem_rd`, `wb_rd`  in  REG_W: destination registers of EX, MEM and WB.
- `ex_mem_read`  in  1: EX instruction is a load.
- `mem_regwrite`, `wb_regwrite`  in  1: MEM or WB writes the regfile.
- `ex_br_taken`  in  1: EX resolves a taken branch or jump.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb`  out  1: stage register enables.
- `flush_if_id`, `flush_id_ex`  out  1: on load, write a NOP or bubble instead of the input.
- `pc_sel`  out  1: 1 means the PC loads the branch target.
- `fwd_a_sel`, `fwd_b_sel`  out  2: EX operand source. 00 is the regfile, 01 is the EX/MEM result, 10 is the MEM/WB result.
- `mem_timeout`  out  1: sticky error flag.
- `stall_cycles`, `flush_count`  out  CNT_W: performance counters.

## Operation
- Priority, highest first: reset, then timeout, then memory freeze, then taken branch, then load-use, then normal flow.
- Reset (`rst`=0): all `load_*`=0, `flush_*`=1, `pc_sel`=0, `fwd_*`=00. On the next edge: FSM goes to RUN, wait counter is 0, `mem_timeout`=0, counters are 0.
- Freeze condition: `freeze = !imem_resp | (dmem_req & !dmem_resp)`.
  - During freeze: all `load_*`=0, `flush_*`=0, `pc_sel`=0.
  - A taken branch held in EX during a freeze is acted on in the first unfrozen cycle.
- Taken branch (not frozen):
  - `pc_sel`=1 and all `load_*`=1.
  - `flush_if_id`=1 and `flush_id_ex`=1.
  - A load-use hazard in the same cycle is ignored, because its instruction is flushed.
- Load-use: `ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
  - `load_pc`=0 and `load_if_id`=0.
  - `load_id_ex`=1 with `flush_id_ex`=1, which inserts a bubble.
  - EX/MEM and MEM/WB advance.
- Normal flow: all `load_*`=1, `flush_*`=0, `pc_sel`=0.
- Forwarding is combinational and independent of the stall logic:
  - `fwd_a_sel`=01 if `mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1`.
  - Otherwise `fwd_a_sel`=10 if `wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1`.
  - Otherwise `fwd_a_sel`=00.
  - `fwd_b_sel` follows the same rules using `ex_rs2`.
  - MEM takes priority over WB. x0 never forwards.
- Watchdog FSM:
  - RUN: on freeze, go to WAIT with the counter at 1.
  - WAIT:
    - If freeze clears, return to RUN and clear the counter.
    - Otherwise increment the counter.
    - If freeze persists at counter==MAX_WAIT, go to TIMEOUT.
  - TIMEOUT: terminal until reset. `mem_timeout`=1 and the pipeline is frozen as above.
  - The counter is `$clog2(MAX_WAIT+1)` bits wide and never wraps.

## Timing
- Enables, flushes, `pc_sel` and forwarding selects are combinational from the current-cycle inputs, with zero latency.
- `mem_timeout` rises on the edge that ends the (MAX_WAIT+1)-th consecutive frozen cycle.
- Counters update on the same edge as the event they count.
- A reset asserted mid-freeze or mid-TIMEOUT wins on that edge.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments in every cycle that is frozen or has a load-use stall.
  - `flush_count` increments on every taken-branch flush.
  - Both saturate at all-ones.
- Undefined: the counter flops are removed and both outputs are tied to 0.

## Test plan
- Reset, then `imem_resp`=1 with no hazards: all `load_*`=1, `flush_*`=0, `fwd_*`=00, `mem_timeout`=0.
- `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1: `load_pc`=`load_if_id`=0, `load_id_ex`=1, `flush_id_ex`=1. Repeat with `ex_rd`=0: no stall.
- `mem_rd`=`wb_rd`=7 with both regwrites set and `ex_rs1`=7: `fwd_a_sel`=01. Clear `mem_regwrite`: `fwd_a_sel`=10.
- `ex_br_taken`=1 coincident with a load-use hazard: `pc_sel`=1, both flushes=1, all `load_*`=1. With `dmem_req`=1 and `dmem_resp`=0 at the same time: all outputs hold at 0 until `dmem_resp`=1.
- MAX_WAIT=15 and `imem_resp`=0 for 16 cycles: `mem_timeout` rises after the 16th edge and stays high after `imem_resp` returns. `rst`=0 for one edge clears it.
- With `PIPE_CTRL_PERF_EN`: 3 frozen cycles plus 2 branch flushes gives `stall_cycles`=3 and `flush_count`=2. Without it, both read 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall, flush and forwarding controller for a 5-stage RV32I pipeline
// (IF, ID, EX, MEM, WB). Replaces the constant stage-register enables of the
// datapath with hazard-aware load/flush enables. Also produces EX operand
// forwarding selects, freezes the pipeline while a memory response is
// outstanding, and raises a sticky timeout flag if that freeze lasts too long.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   defined   : stall_cycles / flush_count are live saturating counters
//   undefined : counter flops are removed, both outputs read 0
//
// Ports
//   clk                          sole clock
//   rst                          synchronous active-low reset
//   imem_resp                    instruction word valid this cycle
//   dmem_req / dmem_resp         MEM-stage access outstanding / completing
//   id_rs1, id_rs2               ID source registers
//   id_use_rs1, id_use_rs2       ID instruction actually reads that source
//   ex_rs1, ex_rs2               EX source registers
//   ex_rd, mem_rd, wb_rd         destination registers of EX, MEM, WB
//   ex_mem_read                  EX instruction is a load
//   mem_regwrite, wb_regwrite    MEM / WB writes the register file
//   ex_br_taken                  EX resolves a taken branch or jump
//   load_*                       PC and stage-register load enables
//   flush_if_id, flush_id_ex     load a NOP/bubble instead of the input
//   pc_sel                       1 selects the branch target for the PC
//   fwd_a_sel, fwd_b_sel         00 regfile, 01 EX/MEM result, 10 MEM/WB result
//   mem_timeout                  sticky watchdog error flag
//   stall_cycles, flush_count    performance counters

module pipeline_ctrl #(
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rs1,
   input  logic [REG_W-1:0] ex_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] mem_rd,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             ex_mem_read,
   input  logic             mem_regwrite,
   input  logic             wb_regwrite,
   input  logic             ex_br_taken,
   output logic             load_pc,
   output logic             load_if_id,
   output logic             load_id_ex,
   output logic             load_ex_mem,
   output logic             load_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             pc_sel,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [REG_W-1:0]  REG_ZERO   = '0;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT,
      ST_TIMEOUT
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_next;

   logic freeze;
   logic hold;
   logic load_use;

   // A memory freeze and the terminal timeout state both stop the pipeline
   // the same way, so they are merged into one hold term.
   assign freeze   = !imem_resp | (dmem_req & !dmem_resp);
   assign hold     = freeze | (state == ST_TIMEOUT);
   assign load_use = ex_mem_read & (ex_rd != REG_ZERO) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));

   // Watchdog state register; reset wins over any freeze or timeout.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Watchdog next state. The counter holds the number of frozen cycles seen
   // so far; it stops at WAIT_LIMIT, so it can never wrap.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      unique case (state)
         ST_RUN: begin
            if (freeze) begin
               state_next    = ST_WAIT;
               wait_cnt_next = WAIT_W'(1);
            end
         end
         ST_WAIT: begin
            if (!freeze) begin
               state_next    = ST_RUN;
               wait_cnt_next = '0;
            end else if (wait_cnt == WAIT_LIMIT) begin
               state_next = ST_TIMEOUT;
            end else begin
               wait_cnt_next = wait_cnt + WAIT_W'(1);
            end
         end
         ST_TIMEOUT: begin
            state_next = ST_TIMEOUT;
         end
         default: begin
            state_next    = ST_RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // Stage enables in priority order. A branch held in EX during a freeze
   // needs no storage: EX does not advance, so ex_br_taken is still asserted
   // in the first unfrozen cycle. A load-use hazard coinciding with a taken
   // branch is ignored because the dependent instruction is flushed anyway.
   always_comb begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      pc_sel      = 1'b0;
      if (!rst) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (hold) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
      end else if (ex_br_taken) begin
         pc_sel      = 1'b1;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (load_use) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         flush_id_ex = 1'b1;
      end
   end

   // Forwarding selects: the younger MEM result beats WB, x0 never forwards.
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (rst) begin
         if (mem_regwrite && mem_rd != REG_ZERO && mem_rd == ex_rs1) begin
            fwd_a_sel = 2'b01;
         end else if (wb_regwrite && wb_rd != REG_ZERO && wb_rd == ex_rs1) begin
            fwd_a_sel = 2'b10;
         end
         if (mem_regwrite && mem_rd != REG_ZERO && mem_rd == ex_rs2) begin
            fwd_b_sel = 2'b01;
         end else if (wb_regwrite && wb_rd != REG_ZERO && wb_rd == ex_rs2) begin
            fwd_b_sel = 2'b10;
         end
      end
   end

   assign mem_timeout = (state == ST_TIMEOUT);

`ifdef PIPE_CTRL_PERF_EN
   logic stall_event;
   logic flush_event;

   assign stall_event = hold | (!ex_br_taken & load_use);
   assign flush_event = !hold & ex_br_taken;

   // Saturating performance counters, updated on the edge ending the event.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_event && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (flush_event && flush_count != '1) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. Each step drives one cycle of inputs,
// pushes the expected control vector and counter values into a scoreboard
// queue, then pops and compares them mid-cycle. Expected counter values come
// from event flags supplied with each step.

module tb_pipeline_ctrl;

   localparam int REG_W    = 5;
   localparam int MAX_WAIT = 15;
   localparam int CNT_W    = 32;

   logic             clk;
   logic             rst;
   logic             imem_resp;
   logic             dmem_req;
   logic             dmem_resp;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [REG_W-1:0] ex_rs1;
   logic [REG_W-1:0] ex_rs2;
   logic [REG_W-1:0] ex_rd;
   logic [REG_W-1:0] mem_rd;
   logic [REG_W-1:0] wb_rd;
   logic             ex_mem_read;
   logic             mem_regwrite;
   logic             wb_regwrite;
   logic             ex_br_taken;
   logic             load_pc;
   logic             load_if_id;
   logic             load_id_ex;
   logic             load_ex_mem;
   logic             load_mem_wb;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             pc_sel;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   pipeline_ctrl #(
      .REG_W   (REG_W),
      .MAX_WAIT(MAX_WAIT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_resp   (imem_resp),
      .dmem_req    (dmem_req),
      .dmem_resp   (dmem_resp),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rs1      (ex_rs1),
      .ex_rs2      (ex_rs2),
      .ex_rd       (ex_rd),
      .mem_rd      (mem_rd),
      .wb_rd       (wb_rd),
      .ex_mem_read (ex_mem_read),
      .mem_regwrite(mem_regwrite),
      .wb_regwrite (wb_regwrite),
      .ex_br_taken (ex_br_taken),
      .load_pc     (load_pc),
      .load_if_id  (load_if_id),
      .load_id_ex  (load_id_ex),
      .load_ex_mem (load_ex_mem),
      .load_mem_wb (load_mem_wb),
      .flush_if_id (flush_if_id),
      .flush_id_ex (flush_id_ex),
      .pc_sel      (pc_sel),
      .fwd_a_sel   (fwd_a_sel),
      .fwd_b_sel   (fwd_b_sel),
      .mem_timeout (mem_timeout),
      .stall_cycles(stall_cycles),
      .flush_count (flush_count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       tag;
      logic [12:0] ctl;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   exp_t        sb[$];
   int          errors;
   int          checks;
   logic [31:0] modelStall;
   logic [31:0] modelFlush;

   // Control vector layout:
   // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
   //  flush_if_id, flush_id_ex, pc_sel, fwd_a_sel, fwd_b_sel, mem_timeout}
   function automatic logic [12:0] ctlv(input logic [4:0] ld, input logic [1:0] fl,
                                        input logic ps, input logic [1:0] fa,
                                        input logic [1:0] fb, input logic to);
      return {ld, fl, ps, fa, fb, to};
   endfunction

   localparam logic [4:0] LD_ALL  = 5'b11111;
   localparam logic [4:0] LD_NONE = 5'b00000;
   localparam logic [4:0] LD_LU   = 5'b00111;

   // Pop the oldest expectation and compare it with what the DUT shows now.
   task automatic checkOutput();
      exp_t        e;
      logic [12:0] obs;
      obs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             flush_if_id, flush_id_ex, pc_sel, fwd_a_sel, fwd_b_sel, mem_timeout};
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("[TB] FAIL scoreboard_empty observed=%0d expected>0", sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         assert (obs === e.ctl) else begin
            errors++;
            $error("[TB] FAIL %s_ctl observed=%b expected=%b", e.tag, obs, e.ctl);
         end
         checks++;
         assert (stall_cycles === e.stall) else begin
            errors++;
            $error("[TB] FAIL %s_stall observed=%0d expected=%0d", e.tag, stall_cycles, e.stall);
         end
         checks++;
         assert (flush_count === e.flush) else begin
            errors++;
            $error("[TB] FAIL %s_flush observed=%0d expected=%0d", e.tag, flush_count, e.flush);
         end
      end
   endtask

   // One cycle: inputs are already driven; queue the expectation, check it
   // mid-cycle, account for this cycle's counter events, advance to the next.
   task automatic applyStimulus(input string tag, input logic [12:0] ctl,
                                input bit stallEv, input bit flushEv);
      exp_t e;
      e.tag = tag;
      e.ctl = ctl;
`ifdef PIPE_CTRL_PERF_EN
      e.stall = modelStall;
      e.flush = modelFlush;
`else
      e.stall = '0;
      e.flush = '0;
`endif
      sb.push_back(e);
      @(negedge clk);
      checkOutput();
      if (!rst) begin
         modelStall = '0;
         modelFlush = '0;
      end else begin
         modelStall = modelStall + 32'(stallEv);
         modelFlush = modelFlush + 32'(flushEv);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clearHazards();
      dmem_req     = 1'b0;
      dmem_resp    = 1'b0;
      imem_resp    = 1'b1;
      id_rs1       = '0;
      id_rs2       = '0;
      id_use_rs1   = 1'b0;
      id_use_rs2   = 1'b0;
      ex_rs1       = '0;
      ex_rs2       = '0;
      ex_rd        = '0;
      mem_rd       = '0;
      wb_rd        = '0;
      ex_mem_read  = 1'b0;
      mem_regwrite = 1'b0;
      wb_regwrite  = 1'b0;
      ex_br_taken  = 1'b0;
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      modelStall = '0;
      modelFlush = '0;
      rst        = 1'b0;
      clearHazards();
      @(posedge clk);
      #1;

      // Reset forces enables low, flushes high, and masks forwarding.
      mem_regwrite = 1'b1;
      mem_rd       = 5'd7;
      ex_rs1       = 5'd7;
      applyStimulus("reset", ctlv(LD_NONE, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0), 0, 0);
      rst = 1'b1;
      clearHazards();
      applyStimulus("normal", ctlv(LD_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 0, 0);

      // Load-use through rs2, then the same with ex_rd = x0.
      ex_mem_read = 1'b1;
      ex_rd       = 5'd5;
      id_rs2      = 5'd5;
      id_use_rs2  = 1'b1;
      applyStimulus("loaduse_rs2", ctlv(LD_LU, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0), 1, 0);
      ex_rd  = 5'd0;
      id_rs2 = 5'd0;
      applyStimulus("loaduse_x0", ctlv(LD_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 0, 0);

      // Matching rs1 that the instruction does not read, then one it does.
      ex_rd      = 5'd3;
      id_rs1     = 5'd3;
      id_use_rs2 = 1'b0;
      applyStimulus("loaduse_unused", ctlv(LD_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 0, 0);
      id_use_rs1 = 1'b1;
      applyStimulus("loaduse_rs1", ctlv(LD_LU, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0), 1, 0);

      // Forwarding: MEM over WB, WB alone, x0 never, operand B from MEM.
      clearHazards();
      mem_rd       = 5'd7;
      wb_rd        = 5'd7;
      mem_regwrite = 1'b1;
      wb_regwrite  = 1'b1;
      ex_rs1       = 5'd7;
      ex_rs2       = 5'd2;
      applyStimulus("fwd_a_mem", ctlv(LD_ALL, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0), 0, 0);
      mem_regwrite = 1'b0;
      applyStimulus("fwd_a_wb", ctlv(LD_ALL, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0), 0, 0);
      mem_regwrite = 1'b1;
      mem_rd       = 5'd0;
      wb_rd        = 5'd0;
      ex_rs1       = 5'd0;
      applyStimulus("fwd_x0", ctlv(LD_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 0, 0);
      mem_rd = 5'd9;
      wb_rd  = 5'd9;
      ex_rs2 = 5'd9;
      applyStimulus("fwd_b_mem", ctlv(LD_ALL, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0), 0, 0);

      // Taken branch wins over a simultaneous load-use hazard.
      clearHazards();
      ex_br_taken = 1'b1;
      ex_mem_read = 1'b1;
      ex_rd       = 5'd4;
      id_rs1      = 5'd4;
      id_use_rs1  = 1'b1;
      applyStimulus("branch_lu", ctlv(LD_ALL, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0), 0, 1);

      // Data-memory freeze holds a pending branch until the response.
      dmem_req = 1'b1;
      applyStimulus("dfreeze_1", ctlv(LD_NONE, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 1, 0);
      applyStimulus("dfreeze_2", ctlv(LD_NONE, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 1, 0);
      dmem_resp = 1'b1;
      applyStimulus("dfreeze_done", ctlv(LD_ALL, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0), 0, 1);

      // Instruction-memory freeze for MAX_WAIT+1 cycles trips the watchdog.
      clearHazards();
      imem_resp = 1'b0;
      for (int i = 0; i <= MAX_WAIT; i++) begin
         applyStimulus($sformatf("ifreeze_%0d", i + 1),
                       ctlv(LD_NONE, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 1, 0);
      end
      imem_resp = 1'b1;
      applyStimulus("timeout_hold1", ctlv(LD_NONE, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1), 1, 0);
      applyStimulus("timeout_hold2", ctlv(LD_NONE, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1), 1, 0);
      rst = 1'b0;
      applyStimulus("timeout_reset", ctlv(LD_NONE, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1), 0, 0);
      rst = 1'b1;
      applyStimulus("post_reset", ctlv(LD_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 0, 0);

      // Counter scenario: three frozen cycles and two branch flushes.
      dmem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus($sformatf("perf_freeze_%0d", i + 1),
                       ctlv(LD_NONE, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 1, 0);
      end
      clearHazards();
      ex_br_taken = 1'b1;
      applyStimulus("perf_branch_1", ctlv(LD_ALL, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0), 0, 1);
      applyStimulus("perf_branch_2", ctlv(LD_ALL, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0), 0, 1);
      clearHazards();
      applyStimulus("perf_final", ctlv(LD_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0), 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
